// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Hazard, flush and halt control for a 5-stage in-order core.
//                Tracks in-flight register writers in a 3-slot shift register
//                (EX, MEM, WB) and stalls dependent ID instructions.
//                A taken branch in EX flushes the fetch path. A halt drains
//                the pipeline and then parks the core until reset.
//  Config      : `define FORWARD_EN  -> only a load in EX causes a stall
//                                       (single-cycle load-use)
//                (undefined)         -> any writer in EX/MEM/WB causes a stall
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wen,
    input  logic        id_is_load,
    input  logic        id_halt,
    input  logic        ex_bch_taken,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    localparam int          NUM_SLOTS = 3;
    localparam int          SLOT_EX   = 0;
    localparam int          SLOT_MEM  = 1;
    localparam int          SLOT_WB   = 2;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    slot_t                  r_slot [NUM_SLOTS];
    slot_t                  w_ex_in;
    logic [NUM_SLOTS-1:0]   w_writer;
    logic [NUM_SLOTS-1:0]   w_match;
    logic [NUM_SLOTS-1:0]   w_slot_valid;
    logic                   w_slots_empty;
    logic                   w_hazard;
    logic                   w_issue;
    logic                   w_stall;
    logic                   w_unused;
    logic [15:0]            r_stall_cnt;

    // Per-slot writer qualification and source-operand match. A slot writing
    // x0 never counts, which also keeps rs==0 from ever matching.
    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot_match
            assign w_slot_valid[i] = r_slot[i].valid;
            assign w_writer[i]     = r_slot[i].valid & r_slot[i].wen &
                                     (r_slot[i].rd != 5'd0);
            assign w_match[i]      = w_writer[i] &
                                     ((id_rs1 == r_slot[i].rd) |
                                      (id_rs2 == r_slot[i].rd));
        end
    endgenerate

    assign w_slots_empty = ~(|w_slot_valid);

`ifdef FORWARD_EN
    // Results are bypassed from EX/MEM/WB; only a load still in EX has no
    // data yet, so that is the sole stall source.
    assign w_hazard = id_valid & w_match[SLOT_EX] & r_slot[SLOT_EX].is_load;
    assign w_unused = ^{w_match[SLOT_WB:SLOT_MEM],
                        r_slot[SLOT_MEM].is_load, r_slot[SLOT_WB].is_load};
`else
    // No bypass network: the register file is only valid once the producer
    // has retired from WB, so every pending writer blocks a consumer.
    assign w_hazard = id_valid & (|w_match);
    assign w_unused = ^{r_slot[SLOT_EX].is_load,
                        r_slot[SLOT_MEM].is_load, r_slot[SLOT_WB].is_load};
`endif

    // Build the entry entering EX: the issuing ID instruction, or a bubble.
    always_comb begin
        w_ex_in = '0;
        if (w_issue) begin
            w_ex_in.valid   = 1'b1;
            w_ex_in.wen     = id_rd_wen;
            w_ex_in.rd      = id_rd;
            w_ex_in.is_load = id_is_load;
        end
    end

    // Pending-writer shift register: advances every cycle, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_slot[SLOT_EX]  <= w_ex_in;
            r_slot[SLOT_MEM] <= r_slot[SLOT_EX];
            r_slot[SLOT_WB]  <= r_slot[SLOT_MEM];
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pipeline control outputs. Branch flush wins over both
    // the hazard stall and a halt; reset overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
        halted      = 1'b0;
        w_issue     = 1'b0;
        w_stall     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (ex_bch_taken) begin
                    // Wrong-path instructions in IF/ID and ID are squashed.
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_hazard) begin
                    // Freeze fetch and ID, push a bubble into EX.
                    w_stall     = 1'b1;
                end else if (id_valid && id_halt) begin
                    // The halt itself enters EX as a bubble, then drain.
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_flush = 1'b0;
                    w_issue     = id_valid;
                end
            end
            ST_DRAIN: begin
                if (w_slots_empty) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            halted      = 1'b0;
            w_issue     = 1'b0;
            w_stall     = 1'b0;
            w_state_nxt = ST_RUN;
        end
    end

    // Saturating count of hazard-stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: id_valid  in  1  ID holds a real (non-bubble) instruction.
REQ-004 SHALL have ports: id_rs1, id_rs2  in  5 each  ID source register addresses.
REQ-005 SHALL have ports: id_rd  in  5  ID destination address.
REQ-006 SHALL have ports: id_rd_wen  in  1  ID instruction writes id_rd.
REQ-007 SHALL have ports: id_is_load  in  1  ID instruction is a memory load.
REQ-008 SHALL have ports: id_halt  in  1  ID instruction is a halt.
REQ-009 SHALL have ports: ex_bch_taken  in  1  EX resolved a taken branch or jump.
REQ-010 SHALL have ports: pc_en  out  1  PC update enable.
REQ-011 SHALL have ports: if_id_en  out  1  IF/ID register load enable.
REQ-012 SHALL have ports: if_id_flush, id_ex_flush  out  1 each  insert a bubble into that register.
REQ-013 SHALL have ports: halted  out  1  core halted, sticky.
REQ-014 SHALL have ports: stall_cnt  out  16  count of hazard-stall cycles.

Function
REQ-015 SHALL keep a 3-slot pending-writer shift register (EX, MEM, WB); each slot holds {valid, rd, is_load}.
REQ-016 SHALL advance the shift register every cycle; the EX slot loads the ID instruction when it issues, else a bubble (valid=0).
REQ-017 SHALL treat a slot as a writer only if valid=1, wen=1 and rd!=0; id_rs1/id_rs2 equal to 0 SHALL never hazard.
REQ-018 SHALL assert hazard (combinational) when id_valid=1 and either source register matches a writer slot selected per REQ-031/032.
REQ-019 SHALL, on hazard without flush: pc_en=0, if_id_en=0, id_ex_flush=1; ID instruction not issued; stall_cnt += 1, saturating at 16'hFFFF.
REQ-020 SHALL, on ex_bch_taken=1: if_id_flush=1, id_ex_flush=1, pc_en=1, no issue; this SHALL override hazard and id_halt in the same cycle, and stall_cnt SHALL NOT increment.
REQ-021 SHALL implement an FSM with states RUN, DRAIN and HALTED.
REQ-022 SHALL, in RUN with neither hazard nor flush: pc_en=1, if_id_en=1, both flushes=0, ID issues.
REQ-023 SHALL transition RUN->DRAIN when id_valid=1, id_halt=1, no hazard and ex_bch_taken=0; the halt itself SHALL issue as a bubble (never recorded as a writer).
REQ-024 SHALL, in DRAIN: pc_en=0, if_id_en=0, id_ex_flush=1.
REQ-025 SHALL transition DRAIN->HALTED once all three slots are invalid, within at most 3 cycles.
REQ-026 SHALL, in HALTED: outputs as in DRAIN and halted=1; only rst leaves HALTED; ex_bch_taken SHALL be ignored in DRAIN and HALTED.

Reset
REQ-027 SHALL, on rst sampled high, clear all slots, set FSM to RUN and set stall_cnt to 0, overriding any in-flight stall, drain or halt.
REQ-028 SHALL hold outputs while rst is high: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=0.
REQ-029 SHALL drive pc_en=1 in the first cycle after rst deasserts, absent a hazard.

Configuration
REQ-030 SHALL use macro FORWARD_EN to select the hazard policy.
REQ-031 SHALL, with FORWARD_EN defined, treat only an EX slot with is_load=1 as a hazard (single-cycle load-use stall).
REQ-032 SHALL, without FORWARD_EN, treat any writer in EX, MEM or WB as a hazard; a dependent instruction then stalls until the producer leaves WB.

Verification
REQ-033 SHALL cover: FORWARD_EN, load x5 then add x6,x5,x1 -> exactly 1 stall cycle, stall_cnt=1.
REQ-034 SHALL cover: no FORWARD_EN, addi x5 then add x6,x5,x5 -> 3 stall cycles, stall_cnt=3.
REQ-035 SHALL cover: producer with rd=x0 followed by a consumer of x0 -> 0 stalls under both configurations.
REQ-036 SHALL cover: ex_bch_taken=1 in the same cycle as a load-use hazard -> both flushes=1, pc_en=1, stall_cnt unchanged.
REQ-037 SHALL cover: halt following two ALU writers -> DRAIN then HALTED within 3 cycles, halted=1, pc_en=0; rst -> RUN, halted=0.
REQ-038 SHALL cover: stall_cnt preloaded to 16'hFFFF by a long stall run, then one more stall -> value remains 16'hFFFF.
